// File: rtl/ram_copy_engine.sv
// Word-by-word copy engine mastering a single-port synchronous RAM (read, capture, write per word).
// Optional build macro CHECKSUM_EN adds a running XOR of every copied word on the checksum port.
module ram_copy_engine #(
    parameter int AW   = 8,
    parameter int DW   = 64,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [7:0]    len,
    output logic          busy,
    output logic          done,
    output logic          cen,
    output logic          wen,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_din,
    input  logic [DW-1:0] s_dout
`ifdef CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [AW-1:0] STEP_V = AW'(STEP);

    logic [2:0]    state_r;
    logic [AW-1:0] src_ptr_r;
    logic [AW-1:0] dst_ptr_r;
    logic [7:0]    cnt_r;

    // Copy sequencer; every RAM-facing output is registered for the cycle it describes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            src_ptr_r <= {AW{1'b0}};
            dst_ptr_r <= {AW{1'b0}};
            cnt_r     <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cen       <= 1'b0;
            wen       <= 1'b0;
            s_addr    <= {AW{1'b0}};
            s_din     <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    cen  <= 1'b0;
                    wen  <= 1'b0;
                    if (start) begin
                        src_ptr_r <= src_addr;
                        dst_ptr_r <= dst_addr;
                        cnt_r     <= len;
                        if (len == 8'd0) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= ST_RD;
                            busy    <= 1'b1;
                            cen     <= 1'b1;
                            s_addr  <= src_addr;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_RD: begin
                    state_r <= ST_CAP;
                    cen     <= 1'b0;
                    wen     <= 1'b0;
                end
                ST_CAP: begin
                    // s_din doubles as the word buffer; the read data is valid only in this cycle.
                    state_r   <= ST_WR;
                    s_din     <= s_dout;
                    src_ptr_r <= src_ptr_r + STEP_V;
                    cen       <= 1'b1;
                    wen       <= 1'b1;
                    s_addr    <= dst_ptr_r;
                end
                ST_WR: begin
                    dst_ptr_r <= dst_ptr_r + STEP_V;
                    cnt_r     <= cnt_r - 8'd1;
                    if (cnt_r == 8'd1) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cen     <= 1'b0;
                        wen     <= 1'b0;
                    end else begin
                        state_r <= ST_RD;
                        cen     <= 1'b1;
                        wen     <= 1'b0;
                        s_addr  <= src_ptr_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    cen     <= 1'b0;
                    wen     <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    cen     <= 1'b0;
                    wen     <= 1'b0;
                end
            endcase
        end
    end

`ifdef CHECKSUM_EN
    // Running XOR of copied words, restarted by each accepted command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= {DW{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            checksum <= {DW{1'b0}};
        end else if (state_r == ST_CAP) begin
            checksum <= checksum ^ s_dout;
        end else begin
            checksum <= checksum;
        end
    end
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
// Self-checking bench for ram_copy_engine with a behavioural RAM and a write scoreboard.
// Build with CHECKSUM_EN defined to also exercise the checksum port.
module tb_ram_copy_engine;
    localparam int AW = 8;
    localparam int DW = 64;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [7:0]    len;
    logic          busy;
    logic          done;
    logic          cen;
    logic          wen;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    logic [DW-1:0] s_dout;
`ifdef CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    ram_copy_engine #(.AW(AW), .DW(DW), .STEP(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .cen(cen), .wen(wen),
        .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
`ifdef CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    // Behavioural RAM plus a bench-side preload port and a log of every real write.
    logic [DW-1:0] mem [0:255];
    logic          pl_clr = 1'b0;
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = 8'h00;
    logic [DW-1:0] pl_data = 64'h0;
    logic [AW-1:0] obs_addr [0:1023];
    logic [DW-1:0] obs_data [0:1023];
    int            obs_wr = 0;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'h0;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (cen && wen) begin
            mem[s_addr]      <= s_din;
            obs_addr[obs_wr] <= s_addr;
            obs_data[obs_wr] <= s_din;
            obs_wr           <= obs_wr + 1;
        end
        if (cen && !wen) s_dout <= mem[s_addr];
    end

    logic [DW-1:0] model_mem [0:255];
    logic [DW-1:0] model_sum;
    wr_t           exp_q[$];
    int            obs_rd = 0;
    int            chk_cnt = 0;
    int            pass_cnt = 0;

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic next_obs(output wr_t got);
        if (obs_rd < obs_wr) begin
            got = {obs_addr[obs_rd], obs_data[obs_rd]};
            obs_rd++;
        end else begin
            got = 'x;
        end
    endtask

    // Called at a negedge; pushes expected writes, issues start, runs until done or timeout.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                            input int ign_cyc, output int done_cyc, output int busy_cyc,
                            output int cen_cyc);
        logic [7:0]    sa;
        logic [7:0]    da;
        logic [DW-1:0] w;
        model_sum = 64'h0;
        for (int k = 0; k < int'(n); k++) begin
            sa = s + 8'(k);
            da = d + 8'(k);
            w  = model_mem[sa];
            model_sum    = model_sum ^ w;
            model_mem[da] = w;
            exp_q.push_back({da, w});
        end
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        done_cyc = -1; busy_cyc = 0; cen_cyc = 0;
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            start = (c == ign_cyc);
            src_addr = ~s; dst_addr = ~d; len = 8'd1;
            if (busy === 1'b1) busy_cyc++;
            if (cen === 1'b1) cen_cyc++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; src_addr = 8'h00; dst_addr = 8'h00; len = 8'd0;
        pl_clr = 1'b1;
        for (int i = 0; i < 256; i++) model_mem[i] = 64'h0;
        @(negedge clk);
        @(negedge clk);
        pl_clr = 1'b0;
        chk_cnt++;
        if ({busy, done, cen, wen} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, cen, wen});
        else pass_cnt++;
        chk_cnt++;
        if (s_addr !== 8'h00) $display("FAIL reset_s_addr: got %h expected 00", s_addr);
        else pass_cnt++;
        chk_cnt++;
        if (s_din !== 64'h0) $display("FAIL reset_s_din: got %h expected 0", s_din);
        else pass_cnt++;
`ifdef CHECKSUM_EN
        chk_cnt++;
        if (checksum !== 64'h0) $display("FAIL reset_checksum: got %h expected 0", checksum);
        else pass_cnt++;
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int dc, bc, cc;
        wr_t e, got;
        preload(8'h00, 64'h1111_1111_1111_1111);
        preload(8'h01, 64'h2222_2222_2222_2222);
        preload(8'h02, 64'h3333_3333_3333_3333);
        run_copy(8'h00, 8'h40, 8'd3, 0, dc, bc, cc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(got);
            chk_cnt++;
            if (got !== e) $display("FAIL basic_write: got %h expected %h", got, e);
            else pass_cnt++;
        end
        chk_cnt++;
        if (obs_rd !== obs_wr) $display("FAIL basic_extra_writes: got %0d expected %0d", obs_wr, obs_rd);
        else pass_cnt++;
        chk_cnt++;
        if (dc !== 10) $display("FAIL basic_done_cycle: got %0d expected 10", dc);
        else pass_cnt++;
        chk_cnt++;
        if (bc !== 9) $display("FAIL basic_busy_cycles: got %0d expected 9", bc);
        else pass_cnt++;
        chk_cnt++;
        if ({mem[8'h40], mem[8'h41], mem[8'h42]} !== {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333})
            $display("FAIL basic_ram: got %h %h %h expected 1111.. 2222.. 3333..", mem[8'h40], mem[8'h41], mem[8'h42]);
        else pass_cnt++;
`ifdef CHECKSUM_EN
        chk_cnt++;
        if (checksum !== 64'h0000_0000_0000_0000) $display("FAIL basic_checksum: got %h expected 0", checksum);
        else pass_cnt++;
`endif
        @(negedge clk);
    endtask

    task automatic test_zero_len;
        int dc, bc, cc;
        int wr_before;
        preload(8'h30, 64'h5A5A_5A5A_5A5A_5A5A);
        wr_before = obs_wr;
        run_copy(8'h00, 8'h30, 8'd0, 0, dc, bc, cc);
        chk_cnt++;
        if (dc !== 1) $display("FAIL zero_done_cycle: got %0d expected 1", dc);
        else pass_cnt++;
        chk_cnt++;
        if ({cc, bc} !== {32'd0, 32'd0}) $display("FAIL zero_cen_busy: got cen=%0d busy=%0d expected 0 0", cc, bc);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({obs_wr, mem[8'h30]} !== {wr_before, 64'h5A5A_5A5A_5A5A_5A5A})
            $display("FAIL zero_ram_unchanged: got writes=%0d ram=%h expected %0d 5a5a..", obs_wr, mem[8'h30], wr_before);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        int dc, bc, cc;
        wr_t e, got;
        preload(8'hFE, 64'hA0A0_0000_0000_00FE);
        preload(8'hFF, 64'hA0A0_0000_0000_00FF);
        preload(8'h00, 64'hA0A0_0000_0000_0100);
        preload(8'h01, 64'hA0A0_0000_0000_0101);
        run_copy(8'hFE, 8'h10, 8'd4, 0, dc, bc, cc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(got);
            chk_cnt++;
            if (got !== e) $display("FAIL wrap_write: got %h expected %h", got, e);
            else pass_cnt++;
        end
        chk_cnt++;
        if (dc !== 13) $display("FAIL wrap_done_cycle: got %0d expected 13", dc);
        else pass_cnt++;
        chk_cnt++;
        if ({mem[8'h12], mem[8'h13]} !== {64'hA0A0_0000_0000_0100, 64'hA0A0_0000_0000_0101})
            $display("FAIL wrap_ram: got %h %h expected a0a0..0100 a0a0..0101", mem[8'h12], mem[8'h13]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_ignored_start;
        int dc, bc, cc;
        wr_t e, got;
        preload(8'h60, 64'h0123_4567_89AB_CDEF);
        preload(8'h61, 64'hFEDC_BA98_7654_3210);
        preload(8'h62, 64'h0F0F_0F0F_F0F0_F0F0);
        run_copy(8'h60, 8'h68, 8'd3, 4, dc, bc, cc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(got);
            chk_cnt++;
            if (got !== e) $display("FAIL ignored_start_write: got %h expected %h", got, e);
            else pass_cnt++;
        end
        chk_cnt++;
        if (dc !== 10) $display("FAIL ignored_start_done_cycle: got %0d expected 10", dc);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({obs_rd == obs_wr, busy, done, cen} !== 4'b1000)
            $display("FAIL ignored_start_after: got eq=%b busy=%b done=%b cen=%b expected 1 0 0 0", obs_rd == obs_wr, busy, done, cen);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int dc, bc, cc;
        wr_t e, got;
        preload(8'h80, 64'hFFFF_FFFF_FFFF_FFFF);
        run_copy(8'h80, 8'h90, 8'd1, 0, dc, bc, cc);
        chk_cnt++;
        if (dc !== 4) $display("FAIL b2b_first_done_cycle: got %0d expected 4", dc);
        else pass_cnt++;
        // start presented during the DONE cycle must be dropped
        src_addr = 8'h00; dst_addr = 8'h00; len = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_cnt++;
        if ({busy, done, cen} !== 3'b000) $display("FAIL b2b_done_cycle_start: got %b expected 000", {busy, done, cen});
        else pass_cnt++;
`ifdef CHECKSUM_EN
        chk_cnt++;
        if (checksum !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL checksum_ones: got %h expected ffff..", checksum);
        else pass_cnt++;
`endif
        run_copy(8'h40, 8'hA0, 8'd2, 0, dc, bc, cc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(got);
            chk_cnt++;
            if (got !== e) $display("FAIL b2b_write: got %h expected %h", got, e);
            else pass_cnt++;
        end
        chk_cnt++;
        if (dc !== 7) $display("FAIL b2b_second_done_cycle: got %0d expected 7", dc);
        else pass_cnt++;
`ifdef CHECKSUM_EN
        chk_cnt++;
        if (checksum !== model_sum) $display("FAIL b2b_checksum: got %h expected %h", checksum, model_sum);
        else pass_cnt++;
`endif
        @(negedge clk);
    endtask

    task automatic test_overlap;
        int dc, bc, cc;
        wr_t e, got;
        preload(8'h20, 64'hAAAA_0000_AAAA_0000);
        preload(8'h21, 64'hBBBB_0000_BBBB_0000);
        run_copy(8'h20, 8'h21, 8'd2, 0, dc, bc, cc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            next_obs(got);
            chk_cnt++;
            if (got !== e) $display("FAIL overlap_write: got %h expected %h", got, e);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({mem[8'h21], mem[8'h22]} !== {64'hAAAA_0000_AAAA_0000, 64'hAAAA_0000_AAAA_0000})
            $display("FAIL overlap_ram: got %h %h expected aaaa0000.. twice", mem[8'h21], mem[8'h22]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int  done_seen;
        wr_t got;
        preload(8'h50, 64'h5000_0000_0000_0000);
        preload(8'h51, 64'h5100_0000_0000_0001);
        preload(8'h52, 64'h5200_0000_0000_0002);
        preload(8'h53, 64'h5300_0000_0000_0003);
        preload(8'h71, 64'hDEAD_BEEF_DEAD_BEEF);
        src_addr = 8'h50; dst_addr = 8'h70; len = 8'd4; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk_cnt++;
        if ({busy, cen, wen, s_addr} !== {3'b111, 8'h71}) $display("FAIL abort_second_wr: got %b %h expected 111 71", {busy, cen, wen}, s_addr);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        chk_cnt++;
        if ({busy, done, cen, wen, s_addr, s_din} !== {4'b0000, 8'h00, 64'h0})
            $display("FAIL abort_outputs: got %b %h %h expected 0000 00 0", {busy, done, cen, wen}, s_addr, s_din);
        else pass_cnt++;
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk_cnt++;
        if (done_seen !== 0) $display("FAIL abort_no_done: got %0d done cycles expected 0", done_seen);
        else pass_cnt++;
        chk_cnt++;
        if ({mem[8'h70], mem[8'h71]} !== {64'h5000_0000_0000_0000, 64'hDEAD_BEEF_DEAD_BEEF})
            $display("FAIL abort_ram: got %h %h expected 5000.. deadbeef..", mem[8'h70], mem[8'h71]);
        else pass_cnt++;
        next_obs(got);
        chk_cnt++;
        if ({got, obs_rd == obs_wr} !== {8'h70, 64'h5000_0000_0000_0000, 1'b1})
            $display("FAIL abort_write_log: got %h eq=%b expected 70/5000.. and no more", got, obs_rd == obs_wr);
        else pass_cnt++;
        model_mem[8'h70] = 64'h5000_0000_0000_0000;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_ignored_start();
        test_back_to_back();
        test_overlap();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
